// File: rtl/cs_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs_acc_pkg
// Brief    : Shared defaults and read-FSM state encoding for cs_accumulator_mc.
// Revision : 1.0 - initial release
// ============================================================================
package cs_acc_pkg;

    localparam int c_DEF_W  = 8;
    localparam int c_DEF_CH = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SNAP = 2'd1;
    localparam logic [1:0] c_ST_OUT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cs_acc_resolve.sv
`default_nettype none
// ============================================================================
// Module   : cs_acc_resolve
// Brief    : Ripple-carry resolution of a redundant (s, c) pair into {co, sum},
//            where the represented value is s + 2*c.
// Revision : 1.0 - initial release
// ============================================================================
module cs_acc_resolve
    import cs_acc_pkg::*;
#(
    parameter int W = c_DEF_W
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W-1:0] w_b;
    logic [W:0]   w_cy;

    assign w_b     = {c[W-2:0], 1'b0};
    assign w_cy[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]    = s[i] ^ w_b[i] ^ w_cy[i];
        assign w_cy[i+1] = (s[i] & w_b[i]) | (s[i] & w_cy[i]) | (w_b[i] & w_cy[i]);
    end

    // c[W-1] carries weight 2^W, so it folds straight into the top result bit
    assign co = w_cy[W] ^ c[W-1];

endmodule
`default_nettype wire

// File: rtl/cs_accumulator_mc.sv
`default_nettype none
// ============================================================================
// Module   : cs_accumulator_mc
// Brief    : Multi-channel carry-save accumulator with a 2-stage handshaked
//            read-out. Optional sticky wrap flags: define OVF_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cs_accumulator_mc
    import cs_acc_pkg::*;
#(
    parameter  int W  = c_DEF_W,
    parameter  int CH = c_DEF_CH,
    localparam int CW = $clog2(CH)
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          in_valid,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  A,
    input  logic          Ci,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [CW-1:0] rd_ch,
    input  logic          rd_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  S,
    output logic          Co,
    output logic          ovf
);

    logic [W-1:0]  r_s [CH];
    logic [W-1:0]  r_c [CH];
    state_t        r_state;
    logic          r_live;
    logic [W-1:0]  r_snap_s;
    logic [W-1:0]  r_snap_c;
    logic          r_snap_ovf;
    logic [W-1:0]  r_sum;
    logic          r_co;
    logic          r_ovf;

    logic          w_rd_fire;
    logic          w_rd_hit;
    logic          w_rd_sticky;
    logic [CH-1:0] w_acc_hit;
    logic [CH-1:0] w_clr_hit;
    logic [W-1:0]  w_base_s [CH];
    logic [W-1:0]  w_base_c [CH];
    logic [W-1:0]  w_x      [CH];
    logic [W-1:0]  w_s_nxt  [CH];
    logic [W-1:0]  w_c_nxt  [CH];
    logic [W-1:0]  w_res_sum;
    logic          w_res_co;

    assign rd_ready  = r_live && (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_OUT);
    assign w_rd_fire = rd_valid && rd_ready;
    assign S         = r_sum;
    assign Co        = r_co;
    assign ovf       = r_ovf;

    if (CH == (1 << CW)) begin : g_rd_full
        assign w_rd_hit = 1'b1;
    end else begin : g_rd_part
        assign w_rd_hit = ({1'b0, rd_ch} < (CW+1)'(CH));
    end

    // A clearing read turns a same-channel accumulate into accumulate-onto-zero
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            w_acc_hit[k] = in_valid && (in_ch == CW'(k));
            w_clr_hit[k] = w_rd_fire && rd_clr && (rd_ch == CW'(k));
            w_base_s[k]  = w_clr_hit[k] ? '0 : r_s[k];
            w_base_c[k]  = w_clr_hit[k] ? '0 : r_c[k];
            w_x[k]       = {w_base_c[k][W-2:0], Ci};
            w_s_nxt[k]   = w_base_s[k] ^ A ^ w_x[k];
            w_c_nxt[k]   = (w_base_s[k] & A) | (w_base_s[k] & w_x[k]) | (A & w_x[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            for (int k = 0; k < CH; k++) begin
                r_s[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (w_acc_hit[k]) begin
                    r_s[k] <= w_s_nxt[k];
                    r_c[k] <= w_c_nxt[k];
                end else if (w_clr_hit[k]) begin
                    r_s[k] <= '0;
                    r_c[k] <= '0;
                end
            end
        end
    end

`ifdef OVF_STICKY_EN
    logic [CH-1:0] r_sticky;

    // Flag a carry landing in the 2^W slot, which the next accumulate discards
    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_sticky <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                r_sticky[k] <= (w_clr_hit[k] ? 1'b0 : r_sticky[k])
                             | (w_acc_hit[k] & w_c_nxt[k][W-1]);
            end
        end
    end

    assign w_rd_sticky = w_rd_hit && r_sticky[rd_ch];
`else
    assign w_rd_sticky = 1'b0;
`endif

    cs_acc_resolve #(
        .W (W)
    ) u_resolve (
        .s   (r_snap_s),
        .c   (r_snap_c),
        .sum (w_res_sum),
        .co  (w_res_co)
    );

    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_state    <= c_ST_IDLE;
            r_live     <= 1'b0;
            r_snap_s   <= '0;
            r_snap_c   <= '0;
            r_snap_ovf <= 1'b0;
            r_sum      <= '0;
            r_co       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rd_fire) begin
                        r_state    <= c_ST_SNAP;
                        r_snap_s   <= w_rd_hit ? r_s[rd_ch] : '0;
                        r_snap_c   <= w_rd_hit ? r_c[rd_ch] : '0;
                        r_snap_ovf <= w_rd_sticky;
                    end
                end
                c_ST_SNAP: begin
                    r_state <= c_ST_OUT;
                    r_sum   <= w_res_sum;
                    r_co    <= w_res_co;
                    r_ovf   <= r_snap_ovf;
                end
                c_ST_OUT: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cs_accumulator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_accumulator_mc
// Brief    : Directed self-checking bench for cs_accumulator_mc (W=8, CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_accumulator_mc;

`ifdef OVF_STICKY_EN
    localparam int c_OVF_EXP = 1;
`else
    localparam int c_OVF_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [7:0] A;
    logic       Ci;
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_ch;
    logic       rd_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] S;
    logic       Co;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cs_accumulator_mc #(
        .W  (8),
        .CH (4)
    ) dut (
        .clk       (clk),
        ._rst      (rst_n),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .A         (A),
        .Ci        (Ci),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_ch     (rd_ch),
        .rd_clr    (rd_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Co        (Co),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [1:0] ch, input logic [7:0] a, input logic ci);
        in_valid = 1'b1;
        in_ch    = ch;
        A        = a;
        Ci       = ci;
        tick();
        in_valid = 1'b0;
        A        = 8'h00;
        Ci       = 1'b0;
    endtask

    task automatic rd(input logic [1:0] ch, input logic clr, input int es, input int eco,
                      input int eovf, input string tag);
        int n = 0;
        while (!rd_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".rd_ready"}, 32'(rd_ready), 1);
        rd_valid = 1'b1;
        rd_ch    = ch;
        rd_clr   = clr;
        tick();
        rd_valid = 1'b0;
        rd_clr   = 1'b0;
        chk({tag, ".snap_out_valid"}, 32'(out_valid), 0);
        tick();
        chk({tag, ".out_valid"}, 32'(out_valid), 1);
        chk({tag, ".S"}, 32'(S), es);
        chk({tag, ".Co"}, 32'(Co), eco);
        chk({tag, ".ovf"}, 32'(ovf), eovf);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        A         = 8'h00;
        Ci        = 1'b0;
        rd_valid  = 1'b0;
        rd_ch     = 2'd0;
        rd_clr    = 1'b0;
        out_ready = 1'b1;

        tick();
        tick();
        chk("rst.rd_ready", 32'(rd_ready), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.S", 32'(S), 0);
        chk("rst.Co", 32'(Co), 0);
        chk("rst.ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        tick();
        chk("rst.rd_ready_after", 32'(rd_ready), 1);

        rd(2'd0, 1'b0, 'h00, 0, 0, "t1");

        acc(2'd1, 8'h05, 1'b0);
        acc(2'd1, 8'h0A, 1'b0);
        acc(2'd1, 8'h03, 1'b0);
        rd(2'd1, 1'b0, 'h12, 0, 0, "t2");

        // 0x10 - 3 = 0x0D, with the two's-complement carry out showing in Co
        acc(2'd2, 8'h10, 1'b0);
        acc(2'd2, 8'hFC, 1'b1);
        rd(2'd2, 1'b0, 'h0D, 1, 0, "t3");

        acc(2'd3, 8'hFF, 1'b0);
        acc(2'd3, 8'hFF, 1'b0);
        rd(2'd3, 1'b1, 'hFE, 1, c_OVF_EXP, "t4a");
        rd(2'd3, 1'b0, 'h00, 0, 0, "t4b");

        acc(2'd0, 8'h07, 1'b0);
        in_valid = 1'b1;
        in_ch    = 2'd0;
        A        = 8'h01;
        rd_valid = 1'b1;
        rd_ch    = 2'd0;
        rd_clr   = 1'b1;
        tick();
        in_valid = 1'b0;
        A        = 8'h00;
        rd_valid = 1'b0;
        rd_clr   = 1'b0;
        chk("t5.snap_rd_ready", 32'(rd_ready), 0);
        tick();
        chk("t5.out_valid", 32'(out_valid), 1);
        chk("t5.S", 32'(S), 'h07);
        chk("t5.Co", 32'(Co), 0);
        tick();
        rd(2'd0, 1'b0, 'h01, 0, 0, "t5b");

        out_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_ch     = 2'd1;
        tick();
        rd_valid  = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd2;
        A         = 8'h01;
        tick();
        in_valid  = 1'b0;
        A         = 8'h00;
        chk("t6.out_valid", 32'(out_valid), 1);
        chk("t6.S", 32'(S), 'h12);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.hold_valid", 32'(out_valid), 1);
            chk("t6.hold_S", 32'(S), 'h12);
            chk("t6.hold_Co", 32'(Co), 0);
            chk("t6.hold_rd_ready", 32'(rd_ready), 0);
        end
        rst_n = 1'b0;
        tick();
        chk("t6.rst_out_valid", 32'(out_valid), 0);
        chk("t6.rst_rd_ready", 32'(rd_ready), 0);
        chk("t6.rst_S", 32'(S), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            rd(2'(k), 1'b0, 'h00, 0, 0, "t6.cleared");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
